bus_endpoint_fifo: RTL and testbench
====================================

Name: bus_endpoint_fifo

Overview:
- Synthesizable device-side endpoint of the shared bus protocol used by bs_gnrtr_n_rbtr: pndng / pop / D_pop on the bus-read side, push / D_push on the bus-write side.
- Contains one TX FIFO, which the device fills and the bus drains.
- Contains one RX FIFO, which the bus fills and the device drains.
- RX accepts only packets addressed to this endpoint's ID or to the broadcast ID.
- One instance per bus port; it replaces the behavioural FIFO model in the bench with real RTL.

Parameters:
- pckg_sz, 16, packet width in bits; destination ID is bits [pckg_sz-1 : pckg_sz-8].
- fifo_size, 8, depth of each FIFO in entries; power of two, >= 2.
- id, 0, 8-bit destination ID of this endpoint.
- broadcast, 8'hFF, destination ID accepted by every endpoint.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dev_wr  in  1  device write strobe into TX FIFO.
- dev_wdata  in  pckg_sz  packet written when dev_wr=1.
- dev_full  out  1  TX FIFO full.
- pndng  out  1  TX FIFO non-empty (bus request).
- D_pop  out  pckg_sz  TX head packet (first-word fall-through).
- pop  in  1  bus removes TX head.
- push  in  1  bus delivers a packet.
- D_push  in  pckg_sz  packet delivered with push.
- dev_rd  in  1  device read request from RX FIFO.
- dev_rdata  out  pckg_sz  registered read data.
- dev_rvalid  out  1  dev_rdata valid; one-cycle pulse.
- rx_count  out  $clog2(fifo_size)+1  RX occupancy.
- tx_ovf  out  1  sticky: dev_wr dropped because TX was full.
- rx_ovf  out  1  sticky: accepted-address push dropped because RX was full.
- pop_err  out  1  sticky: pop received while pndng=0.
- miss_cnt  out  8  saturating count of pushes rejected by address.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - Every pointer, count, sticky flag and miss_cnt clears to 0.
  - Outputs pndng, D_pop, dev_rdata, dev_rvalid, rx_count and dev_full are 0.
  - Reset asserted mid-operation flushes both FIFOs; stored data is lost. Inputs are ignored during any reset cycle.
- TX FIFO:
  - Occupancy tx_cnt ranges 0..fifo_size; pndng = (tx_cnt != 0); dev_full = (tx_cnt == fifo_size).
  - D_pop equals the head entry combinationally when pndng=1, and all zeros otherwise.
  - A write enters on the edge where dev_wr=1. It is visible on D_pop / pndng the next cycle if the FIFO was empty (latency 1).
  - pop=1 with pndng=1 removes the head on that edge; the next entry appears on D_pop the following cycle.
  - pop=1 with pndng=0: no state change; pop_err set.
  - dev_wr and pop together while not empty: both take effect and tx_cnt is unchanged. This holds when full too, because the pop frees a slot.
  - dev_wr while full with no pop: write dropped; tx_ovf set.
  - Pointers wrap modulo fifo_size.
- RX address filter, evaluated on the edge where push=1, with dest = D_push[pckg_sz-1 -: 8]:
  - dest == id or dest == broadcast: accepted.
  - Otherwise: rejected, and miss_cnt increments, saturating at 255.
  - The full packet, header included, is stored.
- RX FIFO:
  - An accepted push is written on the same edge.
  - If RX is full and dev_rd=1 in the same cycle, the push is accepted: the read frees a slot and rx_count is unchanged. If RX is full and dev_rd=0, the packet is dropped and rx_ovf is set.
  - dev_rd=1 with rx_count>0: the head is registered into dev_rdata; dev_rvalid=1 in the next cycle only (latency 1); the entry is removed.
  - dev_rd=1 with rx_count=0: dev_rvalid=0 next cycle; dev_rdata holds its previous value.
  - A packet written on edge N is readable by a dev_rd at cycle N+1 or later; there is no same-cycle bypass.
- Sticky flags clear only on reset.
- The TX and RX paths are fully independent and may both be active in any cycle.

Test Plan:
- Reset, then dev_wr 16'hA123 then 16'hB456 -> pndng=1 one cycle after the first write, D_pop=16'hA123; pop -> D_pop=16'hB456; second pop -> pndng=0, D_pop=0.
- Write 8 packets (fifo_size=8) -> dev_full=1. A ninth dev_wr with no pop -> dropped, tx_ovf=1. A ninth dev_wr together with pop -> accepted, dev_full stays 1.
- id=3: push 16'h0311, 16'hFF22, 16'h0533 -> rx_count=2, miss_cnt=1. dev_rd twice -> dev_rvalid pulses with dev_rdata 16'h0311 then 16'hFF22.
- Fill RX to 8 -> push 16'h0344 without dev_rd is dropped with rx_ovf=1. push 16'h0355 with dev_rd is accepted, rx_count stays 8, and the last read returns 16'h0355.
- pop with pndng=0 -> pop_err=1 and no other state change. dev_rd on empty RX -> dev_rvalid=0.
- Load 3 TX and 3 RX entries, assert reset for one cycle -> pndng=0, rx_count=0, all flags 0, miss_cnt=0. A push of 16'h0366 right after reset is stored normally.

Source files
------------

// File: rtl/bus_endpoint_fifo.sv
// Device-side bus endpoint: a TX FIFO that the device fills and the bus drains (first-word fall-through),
// and an address-filtered RX FIFO that the bus fills and the device drains (registered read).
module bus_endpoint_fifo #(
    parameter int           pckg_sz   = 16,
    parameter int           fifo_size = 8,
    parameter logic [7:0]   id        = 8'd0,
    parameter logic [7:0]   broadcast = 8'hFF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           dev_wr,
    input  logic [pckg_sz-1:0]             dev_wdata,
    output logic                           dev_full,
    output logic                           pndng,
    output logic [pckg_sz-1:0]             D_pop,
    input  logic                           pop,
    input  logic                           push,
    input  logic [pckg_sz-1:0]             D_push,
    input  logic                           dev_rd,
    output logic [pckg_sz-1:0]             dev_rdata,
    output logic                           dev_rvalid,
    output logic [$clog2(fifo_size):0]     rx_count,
    output logic                           tx_ovf,
    output logic                           rx_ovf,
    output logic                           pop_err,
    output logic [7:0]                     miss_cnt
);
    localparam int AW = $clog2(fifo_size);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(fifo_size);

    logic [pckg_sz-1:0] tx_mem [fifo_size];
    logic [pckg_sz-1:0] rx_mem [fifo_size];

    logic [AW-1:0]      tx_wr_ptr_reg, tx_rd_ptr_reg, rx_wr_ptr_reg, rx_rd_ptr_reg;
    logic [CW-1:0]      tx_cnt_reg, tx_cnt_next, rx_cnt_reg, rx_cnt_next;
    logic [pckg_sz-1:0] dev_rdata_reg;
    logic               dev_rvalid_reg;
    logic               tx_ovf_reg, rx_ovf_reg, pop_err_reg;
    logic [7:0]         miss_cnt_reg;

    logic               tx_pop_ok, tx_wr_ok, rx_addr_ok, rx_rd_ok, rx_wr_ok;
    logic [7:0]         rx_dest;

    // A pop frees a slot in the same edge, so a write alongside a pop is allowed even when full.
    assign tx_pop_ok  = pop && (tx_cnt_reg != '0);
    assign tx_wr_ok   = dev_wr && ((tx_cnt_reg != FULL_CNT) || tx_pop_ok);

    assign rx_dest    = D_push[pckg_sz-1 -: 8];
    assign rx_addr_ok = (rx_dest == id) || (rx_dest == broadcast);
    assign rx_rd_ok   = dev_rd && (rx_cnt_reg != '0);
    assign rx_wr_ok   = push && rx_addr_ok && ((rx_cnt_reg != FULL_CNT) || rx_rd_ok);

    always_comb begin
        tx_cnt_next = tx_cnt_reg;
        if (tx_wr_ok && !tx_pop_ok)
            tx_cnt_next = tx_cnt_reg + 1'b1;
        else if (!tx_wr_ok && tx_pop_ok)
            tx_cnt_next = tx_cnt_reg - 1'b1;

        rx_cnt_next = rx_cnt_reg;
        if (rx_wr_ok && !rx_rd_ok)
            rx_cnt_next = rx_cnt_reg + 1'b1;
        else if (!rx_wr_ok && rx_rd_ok)
            rx_cnt_next = rx_cnt_reg - 1'b1;
    end

    // Storage arrays are not reset; the counters alone define what is valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (tx_wr_ok)
                tx_mem[tx_wr_ptr_reg] <= dev_wdata;
            if (rx_wr_ok)
                rx_mem[rx_wr_ptr_reg] <= D_push;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_wr_ptr_reg  <= '0;
            tx_rd_ptr_reg  <= '0;
            tx_cnt_reg     <= '0;
            rx_wr_ptr_reg  <= '0;
            rx_rd_ptr_reg  <= '0;
            rx_cnt_reg     <= '0;
            dev_rdata_reg  <= '0;
            dev_rvalid_reg <= 1'b0;
            tx_ovf_reg     <= 1'b0;
            rx_ovf_reg     <= 1'b0;
            pop_err_reg    <= 1'b0;
            miss_cnt_reg   <= '0;
        end else begin
            tx_cnt_reg     <= tx_cnt_next;
            rx_cnt_reg     <= rx_cnt_next;
            dev_rvalid_reg <= rx_rd_ok;
            if (tx_wr_ok)
                tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
            if (tx_pop_ok)
                tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
            if (rx_wr_ok)
                rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
            // Read-before-write: a full-FIFO read+write on one slot returns the old entry.
            if (rx_rd_ok) begin
                dev_rdata_reg <= rx_mem[rx_rd_ptr_reg];
                rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
            end
            if (dev_wr && !tx_wr_ok)
                tx_ovf_reg <= 1'b1;
            if (push && rx_addr_ok && !rx_wr_ok)
                rx_ovf_reg <= 1'b1;
            if (pop && (tx_cnt_reg == '0))
                pop_err_reg <= 1'b1;
            if (push && !rx_addr_ok && (miss_cnt_reg != 8'hFF))
                miss_cnt_reg <= miss_cnt_reg + 1'b1;
        end
    end

    assign pndng      = (tx_cnt_reg != '0);
    assign dev_full   = (tx_cnt_reg == FULL_CNT);
    assign D_pop      = pndng ? tx_mem[tx_rd_ptr_reg] : '0;
    assign dev_rdata  = dev_rdata_reg;
    assign dev_rvalid = dev_rvalid_reg;
    assign rx_count   = rx_cnt_reg;
    assign tx_ovf     = tx_ovf_reg;
    assign rx_ovf     = rx_ovf_reg;
    assign pop_err    = pop_err_reg;
    assign miss_cnt   = miss_cnt_reg;

endmodule

// File: tb/tb_bus_endpoint_fifo.sv
// Directed bench for bus_endpoint_fifo (id=3): TX ordering/full/overflow, RX filtering/full/overflow,
// error flags, miss counter saturation and mid-operation reset.
module tb_bus_endpoint_fifo;
    logic        clk = 1'b0;
    logic        reset;
    logic        dev_wr;
    logic [15:0] dev_wdata;
    logic        dev_full;
    logic        pndng;
    logic [15:0] D_pop;
    logic        pop;
    logic        push;
    logic [15:0] D_push;
    logic        dev_rd;
    logic [15:0] dev_rdata;
    logic        dev_rvalid;
    logic [3:0]  rx_count;
    logic        tx_ovf;
    logic        rx_ovf;
    logic        pop_err;
    logic [7:0]  miss_cnt;

    int check_cnt = 0;
    int pass_cnt  = 0;

    bus_endpoint_fifo #(
        .pckg_sz(16), .fifo_size(8), .id(8'd3), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset),
        .dev_wr(dev_wr), .dev_wdata(dev_wdata), .dev_full(dev_full),
        .pndng(pndng), .D_pop(D_pop), .pop(pop),
        .push(push), .D_push(D_push),
        .dev_rd(dev_rd), .dev_rdata(dev_rdata), .dev_rvalid(dev_rvalid),
        .rx_count(rx_count), .tx_ovf(tx_ovf), .rx_ovf(rx_ovf),
        .pop_err(pop_err), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("check %-16s got %h", tag, got);
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp_flags, input logic [7:0] exp_miss);
        check({tag, "_flags"}, {29'd0, tx_ovf, rx_ovf, pop_err}, {29'd0, exp_flags});
        check({tag, "_miss"}, {24'd0, miss_cnt}, {24'd0, exp_miss});
    endtask

    initial begin
        reset = 1'b1; dev_wr = 0; dev_wdata = '0; pop = 0; push = 0; D_push = '0; dev_rd = 0;
        tick(); tick();
        reset = 1'b0;
        check("rst_pndng", {31'd0, pndng}, 32'd0);
        check("rst_dpop", {16'd0, D_pop}, 32'd0);
        check("rst_full", {31'd0, dev_full}, 32'd0);
        check("rst_rxcnt", {28'd0, rx_count}, 32'd0);
        check("rst_rvalid", {31'd0, dev_rvalid}, 32'd0);
        check("rst_rdata", {16'd0, dev_rdata}, 32'd0);
        check_flags("rst", 3'b000, 8'd0);

        // TX basic ordering and first-word fall-through
        dev_wr = 1; dev_wdata = 16'hA123; tick();
        check("tx1_pndng", {31'd0, pndng}, 32'd1);
        check("tx1_dpop", {16'd0, D_pop}, 32'h0000A123);
        dev_wdata = 16'hB456; tick(); dev_wr = 0;
        check("tx2_dpop", {16'd0, D_pop}, 32'h0000A123);
        pop = 1; tick(); pop = 0;
        check("tx_pop1", {16'd0, D_pop}, 32'h0000B456);
        pop = 1; tick(); pop = 0;
        check("tx_pop2_pndng", {31'd0, pndng}, 32'd0);
        check("tx_pop2_dpop", {16'd0, D_pop}, 32'd0);

        // TX full, overflow, write+pop while full
        for (int i = 0; i < 8; i++) begin
            dev_wr = 1; dev_wdata = 16'h1000 + 16'(i); tick();
        end
        check("tx_full", {31'd0, dev_full}, 32'd1);
        dev_wdata = 16'h1FFF; tick();
        check("tx_ovf", {31'd0, tx_ovf}, 32'd1);
        check("tx_full_ovf", {31'd0, dev_full}, 32'd1);
        check("tx_head_keep", {16'd0, D_pop}, 32'h00001000);
        dev_wdata = 16'h2AAA; pop = 1; tick(); dev_wr = 0; pop = 0;
        check("tx_full_wrpop", {31'd0, dev_full}, 32'd1);
        for (int i = 1; i < 9; i++) begin
            check("tx_drain", {16'd0, D_pop}, (i < 8) ? 32'h1000 + i : 32'h2AAA);
            pop = 1; tick(); pop = 0;
        end
        check("tx_drained", {31'd0, pndng}, 32'd0);
        check_flags("tx", 3'b100, 8'd0);

        // RX address filter
        push = 1;
        D_push = 16'h0311; tick();
        D_push = 16'hFF22; tick();
        D_push = 16'h0533; tick();
        push = 0;
        check("rx_cnt2", {28'd0, rx_count}, 32'd2);
        check("rx_miss1", {24'd0, miss_cnt}, 32'd1);
        dev_rd = 1; tick();
        check("rx_rv1", {31'd0, dev_rvalid}, 32'd1);
        check("rx_rd1", {16'd0, dev_rdata}, 32'h00000311);
        tick(); dev_rd = 0;
        check("rx_rv2", {31'd0, dev_rvalid}, 32'd1);
        check("rx_rd2", {16'd0, dev_rdata}, 32'h0000FF22);
        tick();
        check("rx_rv_pulse", {31'd0, dev_rvalid}, 32'd0);
        check("rx_rd_hold", {16'd0, dev_rdata}, 32'h0000FF22);
        check("rx_cnt0", {28'd0, rx_count}, 32'd0);

        // RX full, overflow, push+read while full
        push = 1;
        for (int i = 0; i < 8; i++) begin
            D_push = 16'h0300 + 16'(i); tick();
        end
        check("rx_full", {28'd0, rx_count}, 32'd8);
        D_push = 16'h0344; tick();
        check("rx_ovf", {31'd0, rx_ovf}, 32'd1);
        check("rx_cnt_ovf", {28'd0, rx_count}, 32'd8);
        D_push = 16'h0355; dev_rd = 1; tick(); push = 0;
        check("rx_full_wrrd", {28'd0, rx_count}, 32'd8);
        check("rx_fr_data", {16'd0, dev_rdata}, 32'h00000300);
        for (int i = 1; i < 9; i++) begin
            tick();
            check("rx_drain_v", {31'd0, dev_rvalid}, 32'd1);
            check("rx_drain", {16'd0, dev_rdata}, (i < 8) ? 32'h0300 + i : 32'h0355);
        end
        dev_rd = 0;
        check("rx_empty", {28'd0, rx_count}, 32'd0);

        // Errors on empty FIFOs
        pop = 1; tick(); pop = 0;
        check("pop_err", {31'd0, pop_err}, 32'd1);
        check("pop_err_pndng", {31'd0, pndng}, 32'd0);
        check("pop_err_dpop", {16'd0, D_pop}, 32'd0);
        dev_rd = 1; tick(); dev_rd = 0;
        check("rd_empty_v", {31'd0, dev_rvalid}, 32'd0);
        check("rd_empty_hold", {16'd0, dev_rdata}, 32'h00000355);
        check_flags("err", 3'b111, 8'd1);

        // miss_cnt saturates at 255
        push = 1; D_push = 16'h5500;
        for (int i = 0; i < 260; i++) tick();
        push = 0;
        check("miss_sat", {24'd0, miss_cnt}, 32'd255);
        check("miss_rxcnt", {28'd0, rx_count}, 32'd0);

        // Mid-operation reset flushes everything
        for (int i = 0; i < 3; i++) begin
            dev_wr = 1; dev_wdata = 16'h7000 + 16'(i);
            push = 1; D_push = 16'h0360 + 16'(i);
            tick();
        end
        dev_wr = 0; push = 0;
        check("pre_rst_rx", {28'd0, rx_count}, 32'd3);
        reset = 1; dev_wr = 1; push = 1; pop = 1; dev_rd = 1; tick();
        reset = 0; dev_wr = 0; push = 0; pop = 0; dev_rd = 0;
        check("mrst_pndng", {31'd0, pndng}, 32'd0);
        check("mrst_dpop", {16'd0, D_pop}, 32'd0);
        check("mrst_rxcnt", {28'd0, rx_count}, 32'd0);
        check("mrst_full", {31'd0, dev_full}, 32'd0);
        check("mrst_rvalid", {31'd0, dev_rvalid}, 32'd0);
        check("mrst_rdata", {16'd0, dev_rdata}, 32'd0);
        check_flags("mrst", 3'b000, 8'd0);
        push = 1; D_push = 16'h0366; tick(); push = 0;
        check("post_rst_cnt", {28'd0, rx_count}, 32'd1);
        dev_rd = 1; tick(); dev_rd = 0;
        check("post_rst_v", {31'd0, dev_rvalid}, 32'd1);
        check("post_rst_data", {16'd0, dev_rdata}, 32'h00000366);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
